// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, register ids, condition codes, flag bit positions.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] RNONE   = 4'hF;

   typedef enum logic [3:0] {
      C_ALWAYS = 4'h0,
      C_LE     = 4'h1,
      C_L      = 4'h2,
      C_E      = 4'h3,
      C_NE     = 4'h4,
      C_GE     = 4'h5,
      C_G      = 4'h6
   } cond_t;

   localparam int OF_B = 0;
   localparam int ZF_B = 1;
   localparam int SF_B = 2;

   localparam logic [2:0] CC_RESET = 3'b010;

endpackage

// File: rtl/exec_cc_stage_cond_eval.sv
// Combinational jXX/cmovXX condition decode from a CC vector; ifun 7-15 evaluate false.
// Zero latency, no state; shared with the fetch-side predictor checker.
module cond_eval
   import y86_pkg::*;
(
   input  logic [2:0] cc,
   input  logic [3:0] ifun,
   output logic       cnd
);

   logic lt;
   logic zf;

   assign lt = cc[SF_B] ^ cc[OF_B];
   assign zf = cc[ZF_B];

   always_comb begin
      cnd = 1'b0;
      case (ifun)
         C_ALWAYS: cnd = 1'b1;
         C_LE:     cnd = lt | zf;
         C_L:      cnd = lt;
         C_E:      cnd = zf;
         C_NE:     cnd = ~zf;
         C_GE:     cnd = ~lt;
         C_G:      cnd = ~lt & ~zf;
         default:  cnd = 1'b0;
      endcase
   end

endmodule

// File: rtl/exec_cc_stage.sv
// Execute back end: CC register, condition evaluation, E->M pipeline register.
// Latency 1 cycle E->M; e_cnd combinational from registered cc. Stall holds M, bubble loads NOP.
// Optional branch counters br_total/br_taken under EXEC_BR_STATS_EN.
module exec_cc_stage
   import y86_pkg::*;
#(
   parameter int N = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  alu_out,
   input  logic [2:0]    alu_cf,
   input  logic [3:0]    e_icode,
   input  logic [3:0]    e_ifun,
   input  logic [N-1:0]  e_valA,
   input  logic [3:0]    e_dstE,
   input  logic [3:0]    e_dstM,
   input  logic          e_valid,
   input  logic          set_cc,
   input  logic          m_stall,
   input  logic          m_bubble,
   output logic          e_cnd,
   output logic [2:0]    cc,
   output logic [3:0]    M_icode,
   output logic          M_cnd,
   output logic [N-1:0]  M_valE,
   output logic [N-1:0]  M_valA,
   output logic [3:0]    M_dstE,
   output logic [3:0]    M_dstM,
   output logic          M_valid
`ifdef EXEC_BR_STATS_EN
   ,
   output logic [31:0]   br_total,
   output logic [31:0]   br_taken
`endif
);

   logic       cond_raw;
   logic       uses_cond;
   logic [3:0] dste_sel;
   logic       em_load;

   cond_eval u_cond_eval (
      .cc   (cc),
      .ifun (e_ifun),
      .cnd  (cond_raw)
   );

   assign uses_cond = (e_icode == IJXX) || (e_icode == IRRMOVQ);
   assign e_cnd     = e_valid & uses_cond & cond_raw;
   // A cmov whose condition fails must not write back.
   assign dste_sel  = ((e_icode == IRRMOVQ) && !e_cnd) ? RNONE : e_dstE;
   assign em_load   = !m_bubble && !m_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         cc <= CC_RESET;
      end else if (e_valid && (e_icode == IOPQ) && set_cc) begin
         cc <= alu_cf;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || m_bubble || (em_load && !e_valid)) begin
         M_icode <= INOP;
         M_cnd   <= 1'b0;
         M_valE  <= '0;
         M_valA  <= '0;
         M_dstE  <= RNONE;
         M_dstM  <= RNONE;
         M_valid <= 1'b0;
      end else if (em_load) begin
         M_icode <= e_icode;
         M_cnd   <= e_cnd;
         M_valE  <= alu_out;
         M_valA  <= e_valA;
         M_dstE  <= dste_sel;
         M_dstM  <= e_dstM;
         M_valid <= 1'b1;
      end
   end

`ifdef EXEC_BR_STATS_EN
   logic br_count;

   assign br_count = em_load && e_valid && (e_icode == IJXX);

   always_ff @(posedge clk) begin
      if (rst) begin
         br_total <= '0;
         br_taken <= '0;
      end else if (br_count) begin
         if (br_total != 32'hFFFF_FFFF) br_total <= br_total + 32'd1;
         if (e_cnd && (br_taken != 32'hFFFF_FFFF)) br_taken <= br_taken + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_exec_cc_stage.sv
// Self-checking bench for exec_cc_stage: directed scenarios plus randomized traffic vs a reference model.
module tb_exec_cc_stage;

   localparam int N = 64;

   logic          clk;
   logic          rst;
   logic [N-1:0]  alu_out;
   logic [2:0]    alu_cf;
   logic [3:0]    e_icode;
   logic [3:0]    e_ifun;
   logic [N-1:0]  e_valA;
   logic [3:0]    e_dstE;
   logic [3:0]    e_dstM;
   logic          e_valid;
   logic          set_cc;
   logic          m_stall;
   logic          m_bubble;
   logic          e_cnd;
   logic [2:0]    cc;
   logic [3:0]    M_icode;
   logic          M_cnd;
   logic [N-1:0]  M_valE;
   logic [N-1:0]  M_valA;
   logic [3:0]    M_dstE;
   logic [3:0]    M_dstM;
   logic          M_valid;
`ifdef EXEC_BR_STATS_EN
   logic [31:0]   br_total;
   logic [31:0]   br_taken;
   longint        r_total;
   longint        r_taken;
`endif

   int checks = 0;
   int errors = 0;

   // reference state
   logic [2:0]    r_cc;
   logic [3:0]    r_icode;
   logic          r_cnd;
   logic [N-1:0]  r_valE;
   logic [N-1:0]  r_valA;
   logic [3:0]    r_dstE;
   logic [3:0]    r_dstM;
   logic          r_valid;

   exec_cc_stage #(.N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .alu_out  (alu_out),
      .alu_cf   (alu_cf),
      .e_icode  (e_icode),
      .e_ifun   (e_ifun),
      .e_valA   (e_valA),
      .e_dstE   (e_dstE),
      .e_dstM   (e_dstM),
      .e_valid  (e_valid),
      .set_cc   (set_cc),
      .m_stall  (m_stall),
      .m_bubble (m_bubble),
      .e_cnd    (e_cnd),
      .cc       (cc),
      .M_icode  (M_icode),
      .M_cnd    (M_cnd),
      .M_valE   (M_valE),
      .M_valA   (M_valA),
      .M_dstE   (M_dstE),
      .M_dstM   (M_dstM),
      .M_valid  (M_valid)
`ifdef EXEC_BR_STATS_EN
      ,
      .br_total (br_total),
      .br_taken (br_taken)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Condition truth table from flag semantics: "less" means SF differs from OF.
   function automatic bit ref_cond(input logic [2:0] f, input logic [3:0] fn);
      bit of_f = f[0];
      bit zf_f = f[1];
      bit sf_f = f[2];
      bit less = (sf_f != of_f);
      case (int'(fn))
         0: return 1'b1;
         1: return less || zf_f;
         2: return less;
         3: return zf_f;
         4: return !zf_f;
         5: return !less;
         6: return !less && !zf_f;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit ref_ecnd();
      if (!e_valid) return 1'b0;
      if (e_icode != 4'h7 && e_icode != 4'h2) return 1'b0;
      return ref_cond(r_cc, e_ifun);
   endfunction

   task automatic ref_nop();
      r_icode = 4'h1; r_cnd = 1'b0; r_valE = '0; r_valA = '0;
      r_dstE = 4'hF; r_dstM = 4'hF; r_valid = 1'b0;
   endtask

   // Advance the reference by one clock edge using the inputs currently applied.
   task automatic ref_edge();
      bit ec = ref_ecnd();
      bit is_load = !m_bubble && !m_stall;
      if (rst) begin
         r_cc = 3'b010;
         ref_nop();
`ifdef EXEC_BR_STATS_EN
         r_total = 0; r_taken = 0;
`endif
         return;
      end
`ifdef EXEC_BR_STATS_EN
      if (is_load && e_valid && e_icode == 4'h7) begin
         if (r_total < 64'hFFFF_FFFF) r_total++;
         if (ec && r_taken < 64'hFFFF_FFFF) r_taken++;
      end
`endif
      if (m_bubble) ref_nop();
      else if (m_stall) begin
      end else if (!e_valid) ref_nop();
      else begin
         r_icode = e_icode; r_cnd = ec; r_valE = alu_out; r_valA = e_valA;
         r_dstE  = (e_icode == 4'h2 && !ec) ? 4'hF : e_dstE;
         r_dstM  = e_dstM; r_valid = 1'b1;
      end
      if (e_valid && e_icode == 4'h6 && set_cc) r_cc = alu_cf;
   endtask

   task automatic tick();
      ref_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                        input logic [2:0] cf, input logic sc);
      e_icode  = ic;
      e_ifun   = fn;
      alu_cf   = cf;
      set_cc   = sc;
      e_valid  = 1'b1;
      alu_out  = {$urandom, $urandom};
      e_valA   = {$urandom, $urandom};
      e_dstE   = 4'(($urandom % 15));
      e_dstM   = 4'(($urandom % 15));
      m_stall  = 1'b0;
      m_bubble = 1'b0;
      rst      = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      drive(4'h7, 4'h0, 3'b000, 1'b0);
      #1;
      checks++; if (cc !== 3'b010) begin errors++; $display("FAIL reset_cc got %b want 010", cc); end
      checks++; if (M_icode !== 4'h1) begin errors++; $display("FAIL reset_icode got %h want 1", M_icode); end
      checks++; if (M_dstE !== 4'hF || M_dstM !== 4'hF) begin errors++; $display("FAIL reset_dst got %h/%h want F/F", M_dstE, M_dstM); end
      checks++; if (M_valid !== 1'b0 || M_cnd !== 1'b0) begin errors++; $display("FAIL reset_valid_cnd got %b/%b want 0/0", M_valid, M_cnd); end
      checks++; if (M_valE !== '0 || M_valA !== '0) begin errors++; $display("FAIL reset_vals got %h/%h want 0/0", M_valE, M_valA); end
      checks++; if (e_cnd !== 1'b1) begin errors++; $display("FAIL reset_jmp_ecnd got %b want 1", e_cnd); end
   endtask

   task automatic test_cc_cond();
      drive(4'h6, 4'h0, 3'b100, 1'b1);
      #1;
      checks++; if (e_cnd !== 1'b0) begin errors++; $display("FAIL opq_ecnd got %b want 0", e_cnd); end
      tick();
      drive(4'h7, 4'h2, 3'b000, 1'b0);
      #1;
      checks++; if (cc !== 3'b100) begin errors++; $display("FAIL cc_after_opq got %b want 100", cc); end
      checks++; if (e_cnd !== 1'b1) begin errors++; $display("FAIL jl_taken got %b want 1", e_cnd); end
      e_ifun = 4'h5;
      #1;
      checks++; if (e_cnd !== 1'b0) begin errors++; $display("FAIL jge_not_taken got %b want 0", e_cnd); end
      e_valid = 1'b0; e_ifun = 4'h0;
      #1;
      checks++; if (e_cnd !== 1'b0) begin errors++; $display("FAIL invalid_ecnd got %b want 0", e_cnd); end
      tick();
   endtask

   task automatic test_set_cc_gate();
      drive(4'h6, 4'h1, 3'b000, 1'b1);
      tick();
      drive(4'h6, 4'h1, 3'b010, 1'b0);
      tick();
      drive(4'h7, 4'h3, 3'b000, 1'b0);
      #1;
      checks++; if (cc !== 3'b000) begin errors++; $display("FAIL setcc_gated got %b want 000", cc); end
      checks++; if (e_cnd !== 1'b0) begin errors++; $display("FAIL je_after_gate got %b want 0", e_cnd); end
      tick();
   endtask

   task automatic test_cmov();
      drive(4'h6, 4'h0, 3'b010, 1'b1);
      tick();
      drive(4'h2, 4'h4, 3'b000, 1'b0);
      e_dstE = 4'h3;
      tick();
      checks++; if (M_dstE !== 4'hF || M_cnd !== 1'b0) begin errors++; $display("FAIL cmovne_zf1 got dstE=%h cnd=%b want F/0", M_dstE, M_cnd); end
      drive(4'h6, 4'h0, 3'b000, 1'b1);
      tick();
      drive(4'h2, 4'h4, 3'b000, 1'b0);
      e_dstE = 4'h3;
      tick();
      checks++; if (M_dstE !== 4'h3 || M_cnd !== 1'b1) begin errors++; $display("FAIL cmovne_zf0 got dstE=%h cnd=%b want 3/1", M_dstE, M_cnd); end
   endtask

   task automatic test_stall_bubble();
      drive(4'h3, 4'h0, 3'b000, 1'b0);
      alu_out = 64'h1234_5678_9ABC_DEF0;
      e_valA  = 64'h0FED_CBA9_8765_4321;
      e_dstE  = 4'h2;
      e_dstM  = 4'hF;
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(4'h6, 4'(i), 3'(i + 4), 1'b1);
         m_stall = 1'b1;
         tick();
         checks++;
         if (M_icode !== 4'h3 || M_valE !== 64'h1234_5678_9ABC_DEF0 ||
             M_valA !== 64'h0FED_CBA9_8765_4321 || M_dstE !== 4'h2 ||
             M_dstM !== 4'hF || M_valid !== 1'b1 || M_cnd !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d got icode=%h valE=%h dstE=%h valid=%b want 3/123456789abcdef0/2/1",
                     i, M_icode, M_valE, M_dstE, M_valid);
         end
         checks++; if (cc !== 3'(i + 4)) begin errors++; $display("FAIL stall_cc%0d got %b want %b", i, cc, 3'(i + 4)); end
      end
      drive(4'h6, 4'h0, 3'b001, 1'b1);
      m_stall = 1'b1; m_bubble = 1'b1;
      tick();
      checks++; if (M_icode !== 4'h1 || M_valid !== 1'b0 || M_dstE !== 4'hF) begin errors++; $display("FAIL bubble got icode=%h valid=%b dstE=%h want 1/0/F", M_icode, M_valid, M_dstE); end
      checks++; if (cc !== 3'b001) begin errors++; $display("FAIL bubble_cc got %b want 001", cc); end
   endtask

   task automatic test_rst_override();
      drive(4'h6, 4'h0, 3'b101, 1'b1);
      rst = 1'b1;
      tick();
      checks++; if (cc !== 3'b010) begin errors++; $display("FAIL rst_over_setcc got %b want 010", cc); end
      rst = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         logic [3:0] ic;
         case ($urandom_range(0, 5))
            0, 1:    ic = 4'h6;
            2, 3:    ic = 4'h7;
            4:       ic = 4'h2;
            default: ic = 4'($urandom_range(0, 11));
         endcase
         drive(ic, 4'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0));
         e_valid  = ($urandom_range(0, 7) != 0);
         m_stall  = ($urandom_range(0, 5) == 0);
         m_bubble = ($urandom_range(0, 7) == 0);
         rst      = ($urandom_range(0, 49) == 0);
         #1;
         checks++; if (e_cnd !== ref_ecnd()) begin errors++; $display("FAIL rnd_ecnd[%0d] got %b want %b", i, e_cnd, ref_ecnd()); end
         tick();
         checks++; if (cc !== r_cc) begin errors++; $display("FAIL rnd_cc[%0d] got %b want %b", i, cc, r_cc); end
         checks++;
         if (M_icode !== r_icode || M_cnd !== r_cnd || M_valE !== r_valE || M_valA !== r_valA ||
             M_dstE !== r_dstE || M_dstM !== r_dstM || M_valid !== r_valid) begin
            errors++;
            $display("FAIL rnd_em[%0d] got %h %b %h %h %h %h %b want %h %b %h %h %h %h %b", i,
                     M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM, M_valid,
                     r_icode, r_cnd, r_valE, r_valA, r_dstE, r_dstM, r_valid);
         end
`ifdef EXEC_BR_STATS_EN
         checks++; if (br_total !== 32'(r_total) || br_taken !== 32'(r_taken)) begin errors++; $display("FAIL rnd_stats[%0d] got %0d/%0d want %0d/%0d", i, br_total, br_taken, r_total, r_taken); end
`endif
      end
   endtask

`ifdef EXEC_BR_STATS_EN
   task automatic test_br_stats();
      rst = 1'b1;
      tick();
      // cc resets to ZF=1: jmp taken, je taken, jne not taken
      drive(4'h7, 4'h0, 3'b000, 1'b0); tick();
      drive(4'h7, 4'h3, 3'b000, 1'b0); tick();
      drive(4'h7, 4'h4, 3'b000, 1'b0); tick();
      drive(4'h7, 4'h0, 3'b000, 1'b0); m_stall = 1'b1; tick();
      drive(4'h7, 4'h0, 3'b000, 1'b0); m_bubble = 1'b1; tick();
      checks++; if (br_total !== 32'd3) begin errors++; $display("FAIL br_total got %0d want 3", br_total); end
      checks++; if (br_taken !== 32'd2) begin errors++; $display("FAIL br_taken got %0d want 2", br_taken); end
   endtask
`endif

   initial begin
      rst = 1'b1; alu_out = '0; alu_cf = '0; e_icode = 4'h1; e_ifun = '0;
      e_valA = '0; e_dstE = 4'hF; e_dstM = 4'hF; e_valid = 1'b0;
      set_cc = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
      test_reset();
      test_cc_cond();
      test_set_cc_gate();
      test_cmov();
      test_stall_bubble();
      test_rst_override();
      test_random();
`ifdef EXEC_BR_STATS_EN
      test_br_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
